// File: rtl/pipe_stall_ctrl.sv
// Purpose : merges N stall requesters into a per-stage hold vector, issues registered flush/redirect
//           pulses, and keeps saturating stall/flush event counters plus a consecutive-stall watchdog.
// Latency : stall is combinational (0 cycles); flush/new_pc_valid/new_pc appear 1 cycle after flush_req.
// Backpr. : none; stall is the backpressure this block applies to the pipeline, and flush overrides it.
// Ports   : clk, rst (async active-low), stallreq[NUM_REQ], flush_req, flush_pc[32], clr_cnt ->
//           stall[NUM_STAGES], flush[NUM_STAGES], new_pc_valid, new_pc[32], stall_cnt, flush_cnt, stall_timeout.
// NUM_REQ must be at least 1.
module pipe_stall_ctrl #(
    parameter int                     NUM_STAGES    = 6,
    parameter int                     NUM_REQ       = 2,
    parameter logic [4*NUM_REQ-1:0]   REQ_STAGE_VEC = 8'h32,
    parameter int                     CNT_W         = 32,
    parameter int                     TIMEOUT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    stallreq,
    input  logic                  flush_req,
    input  logic [31:0]           flush_pc,
    input  logic                  clr_cnt,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  new_pc_valid,
    output logic [31:0]           new_pc,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  stall_timeout
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    // Hold mask for one source: stages 0..s, with s clamped to the last stage.
    function automatic logic [NUM_STAGES-1:0] stage_mask(input int r);
        int                    s;
        logic [NUM_STAGES-1:0] m;
        s = int'(REQ_STAGE_VEC[4*r +: 4]);
        if (s > NUM_STAGES - 1) begin
            s = NUM_STAGES - 1;
        end
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= s) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    logic                  flush_q,       flush_d;
    logic [31:0]           new_pc_q,      new_pc_d;
    logic [CNT_W-1:0]      stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q,   flush_cnt_d;
    logic [WD_W-1:0]       wd_cnt_q,      wd_cnt_d;
    logic                  timeout_q,     timeout_d;
    logic [NUM_STAGES-1:0] stall_merged;

    always_comb begin
        stall_merged = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (stallreq[r]) begin
                stall_merged = stall_merged | stage_mask(r);
            end
        end
    end

    // A flush cycle loads bubbles everywhere, so holding any stage would be contradictory.
    assign stall         = (rst && !flush_q) ? stall_merged : '0;
    assign flush         = {NUM_STAGES{flush_q}};
    assign new_pc_valid  = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = timeout_q;

    always_comb begin
        flush_d     = flush_req;
        new_pc_d    = flush_req ? flush_pc : new_pc_q;

        stall_cnt_d = stall_cnt_q;
        if (stall[0] && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        // A flush pulse is counted at the edge that launches it.
        flush_cnt_d = flush_cnt_q;
        if (flush_req && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end

        wd_cnt_d = '0;
        if (TIMEOUT > 0 && stall[0]) begin
            wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q || (TIMEOUT > 0 && wd_cnt_d == WD_LIMIT);

        // Clear beats any increment landing on the same edge.
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            wd_cnt_d    = '0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q     <= 1'b0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    stallreq_known_a: assert property (@(posedge clk) disable iff (!rst) !$isunknown(stallreq));

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int T_OUT = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    stallreq;
    logic          flush_req;
    logic [31:0]   flush_pc;
    logic          clr_cnt;
    logic [5:0]    stall;
    logic [5:0]    flush;
    logic          new_pc_valid;
    logic [31:0]   new_pc;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          stall_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stall_ctrl #(
        .NUM_STAGES(6), .NUM_REQ(2), .REQ_STAGE_VEC(8'h32), .CNT_W(CW), .TIMEOUT(T_OUT)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
        .clr_cnt(clr_cnt), .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid),
        .new_pc(new_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Source 0 holds up to ID (stage 2), source 1 up to EX (stage 3).
    int          src_stage [2] = '{2, 3};
    bit          m_flush;
    logic [31:0] m_pc;
    int          m_scnt, m_fcnt, m_run;
    bit          m_tmo;

    // Stall vector = all stages up to the deepest stage any active source asks for.
    function automatic logic [5:0] exp_stall(input logic [1:0] req, input bit fl, input logic rs);
        int deepest;
        deepest = -1;
        for (int r = 0; r < 2; r++) begin
            if (req[r] && src_stage[r] > deepest) deepest = src_stage[r];
        end
        if (!rs || fl || deepest < 0) return 6'd0;
        return 6'((1 << (deepest + 1)) - 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_flush = 0; m_pc = '0; m_scnt = 0; m_fcnt = 0; m_run = 0; m_tmo = 0;
        end else begin
            logic [5:0] es;
            es = exp_stall(stallreq, m_flush, rst);
            if (clr_cnt) begin
                m_scnt = 0; m_fcnt = 0; m_run = 0; m_tmo = 0;
            end else begin
                if (es[0] && m_scnt < CMAX) m_scnt++;
                if (flush_req && m_fcnt < CMAX) m_fcnt++;
                if (es[0]) m_run = (m_run < T_OUT) ? m_run + 1 : T_OUT;
                else m_run = 0;
                if (m_run == T_OUT) m_tmo = 1;
            end
            m_flush = flush_req;
            if (flush_req) m_pc = flush_pc;
        end
    end

    always @(negedge clk) begin
        chk("stall",         64'(stall),         64'(exp_stall(stallreq, m_flush, rst)));
        chk("flush",         64'(flush),         m_flush ? 64'h3F : 64'h0);
        chk("new_pc_valid",  64'(new_pc_valid),  64'(m_flush));
        chk("new_pc",        64'(new_pc),        64'(m_pc));
        chk("stall_cnt",     64'(stall_cnt),     64'(m_scnt));
        chk("flush_cnt",     64'(flush_cnt),     64'(m_fcnt));
        chk("stall_timeout", 64'(stall_timeout), 64'(m_tmo));
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stallreq = 2'b11; flush_req = 1'b1; flush_pc = 32'h1234; clr_cnt = 1'b0;
        #2;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_npv",   64'(new_pc_valid), 64'h0);
        nxt(); nxt();
        chk("rst_flush_held", 64'(flush), 64'h0);
        stallreq = 2'b00; flush_req = 1'b0; rst = 1'b1;

        // merge
        stallreq = 2'b01; @(negedge clk); chk("lit_src0", 64'(stall), 64'h07);
        nxt(); stallreq = 2'b10; @(negedge clk); chk("lit_src1", 64'(stall), 64'h0F);
        nxt(); stallreq = 2'b11; @(negedge clk); chk("lit_both", 64'(stall), 64'h0F);
        nxt(); stallreq = 2'b00; @(negedge clk);
        chk("lit_none", 64'(stall), 64'h0);
        chk("lit_scnt3", 64'(stall_cnt), 64'd3);

        // single flush with stall held
        nxt(); stallreq = 2'b10; flush_req = 1'b1; flush_pc = 32'hBFC00380;
        @(negedge clk); chk("lit_preflush_stall", 64'(stall), 64'h0F);
        nxt(); flush_req = 1'b0; @(negedge clk);
        chk("lit_flush", 64'(flush), 64'h3F);
        chk("lit_npv", 64'(new_pc_valid), 64'h1);
        chk("lit_newpc", 64'(new_pc), 64'hBFC00380);
        chk("lit_flush_stall0", 64'(stall), 64'h0);
        chk("lit_fcnt1", 64'(flush_cnt), 64'd1);
        nxt(); @(negedge clk);
        chk("lit_post_stall", 64'(stall), 64'h0F);
        chk("lit_post_scnt", 64'(stall_cnt), 64'd4);

        // back-to-back flushes
        nxt(); stallreq = 2'b00; clr_cnt = 1'b1;
        nxt(); clr_cnt = 1'b0; flush_req = 1'b1; flush_pc = 32'hA0000000;
        nxt(); flush_pc = 32'hB0000004; @(negedge clk); chk("lit_pc_a", 64'(new_pc), 64'hA0000000);
        nxt(); flush_pc = 32'hC0000008; @(negedge clk); chk("lit_pc_b", 64'(new_pc), 64'hB0000004);
        nxt(); flush_req = 1'b0; @(negedge clk);
        chk("lit_pc_c", 64'(new_pc), 64'hC0000008);
        chk("lit_fcnt3", 64'(flush_cnt), 64'd3);
        nxt(); @(negedge clk);
        chk("lit_npv_off", 64'(new_pc_valid), 64'h0);
        chk("lit_pc_hold", 64'(new_pc), 64'hC0000008);

        // watchdog
        nxt(); stallreq = 2'b01;
        repeat (3) nxt();
        @(negedge clk); chk("lit_tmo_3", 64'(stall_timeout), 64'h0);
        nxt(); stallreq = 2'b00; @(negedge clk); chk("lit_tmo_4", 64'(stall_timeout), 64'h1);
        nxt(); clr_cnt = 1'b1;
        nxt(); clr_cnt = 1'b0; @(negedge clk); chk("lit_tmo_clr", 64'(stall_timeout), 64'h0);
        nxt(); stallreq = 2'b01; repeat (2) nxt();
        nxt(); stallreq = 2'b00;
        nxt(); stallreq = 2'b01; repeat (2) nxt();
        nxt(); stallreq = 2'b00; @(negedge clk); chk("lit_tmo_gap", 64'(stall_timeout), 64'h0);

        // counter saturation and clear-beats-increment
        nxt(); clr_cnt = 1'b1;
        nxt(); clr_cnt = 1'b0; stallreq = 2'b01;
        repeat (9) nxt();
        nxt(); @(negedge clk); chk("lit_scnt_sat", 64'(stall_cnt), 64'd7);
        clr_cnt = 1'b1;
        nxt(); clr_cnt = 1'b0; stallreq = 2'b00; @(negedge clk);
        chk("lit_scnt_clr", 64'(stall_cnt), 64'd0);

        // reset during a flush pulse
        nxt(); flush_req = 1'b1; flush_pc = 32'h8000_0180;
        nxt(); flush_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("lit_rst_flush", 64'(flush), 64'h0);
        chk("lit_rst_npv", 64'(new_pc_valid), 64'h0);
        chk("lit_rst_pc", 64'(new_pc), 64'h0);
        nxt(); rst = 1'b1; @(negedge clk);
        chk("lit_norelaunch", 64'(new_pc_valid), 64'h0);
        nxt(); flush_req = 1'b1; flush_pc = 32'h1111_2220;
        nxt(); flush_req = 1'b0; @(negedge clk);
        chk("lit_after_rst_npv", 64'(new_pc_valid), 64'h1);
        chk("lit_after_rst_pc", 64'(new_pc), 64'h1111_2220);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if ($urandom_range(0, 3) == 0) stallreq = 2'($urandom);
            flush_req = ($urandom_range(0, 7) == 0);
            flush_pc  = $urandom;
            clr_cnt   = ($urandom_range(0, 40) == 0);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b0;
            end
        end
        nxt(); rst = 1'b1; stallreq = 2'b00; flush_req = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
